// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the MIPS datapath slice.
// Holds the multiply/divide op encoding, the mult_div_unit FSM state type,
// the data width and the iteration count of the iterative multiply/divide.
package mips_pkg;

  localparam int DATA_32_W = 32;
  localparam int MD_ITER   = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } t_md_op;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } t_md_state;

  // Two's-complement magnitude of a value when the op treats it as signed.
  function automatic logic [DATA_32_W-1:0] md_mag(input logic [DATA_32_W-1:0] value,
                                                  input logic                 is_signed);
    md_mag = (is_signed && value[DATA_32_W-1]) ? (~value + 1'b1) : value;
  endfunction

endpackage

// File: rtl/md_step.sv
// md_step: one iteration of the iterative multiply/divide, purely combinational.
//   is_div   in  1   0 = shift-add multiply step, 1 = restoring divide step
//   acc      in  64  multiply: {partial product hi, remaining multiplier bits}
//                    divide:   acc[31:0] = {remaining dividend bits, quotient bits}
//   rem      in  32  divide partial remainder (always < divisor between steps)
//   operand  in  32  multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_nxt  out 64  accumulator after this iteration
//   rem_nxt  out 32  partial remainder after this iteration
module md_step
  import mips_pkg::*;
(
  input  logic                   is_div,
  input  logic [63:0]            acc,
  input  logic [DATA_32_W-1:0]   rem,
  input  logic [DATA_32_W-1:0]   operand,
  output logic [63:0]            acc_nxt,
  output logic [DATA_32_W-1:0]   rem_nxt
);

  logic [DATA_32_W:0] sum;      // upper half plus multiplicand, with carry
  logic [DATA_32_W:0] shifted;  // 33-bit partial remainder after the left shift
  logic [DATA_32_W:0] diff;
  logic               geq;

  always_comb begin
    sum     = {1'b0, acc[63:32]} + {1'b0, operand};
    shifted = {rem, acc[31]};
    diff    = shifted - {1'b0, operand};
    geq     = (shifted >= {1'b0, operand});
    acc_nxt = acc;
    rem_nxt = rem;
    if (is_div) begin
      // Restoring step: the quotient bit enters at the bottom as the
      // dividend bit leaves at the top. The remainder after a successful
      // subtract is < divisor, so it always fits back into 32 bits.
      rem_nxt = geq ? diff[DATA_32_W-1:0] : shifted[DATA_32_W-1:0];
      acc_nxt = {acc[63:32], acc[30:0], geq};
    end else begin
      // Shift-add step: LSB of the multiplier decides whether to add; the
      // carry out of the add becomes the new top bit after the right shift.
      if (acc[0]) acc_nxt = {sum, acc[31:1]};
      else        acc_nxt = {1'b0, acc[63:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO.
//   clk        in  1   clock, rising edge
//   rst        in  1   asynchronous active-low reset
//   md_start   in  1   start request (op and operands sampled with it)
//   md_op      in  2   MD_MULT / MD_MULTU / MD_DIV / MD_DIVU
//   md_src_a   in  32  rs: multiplicand / dividend
//   md_src_b   in  32  rt: multiplier / divisor
//   md_hi_wr   in  1   MTHI strobe
//   md_lo_wr   in  1   MTLO strobe
//   md_wr_data in  32  MTHI/MTLO data
//   md_busy    out 1   operation in progress
//   md_done    out 1   one-cycle pulse, HI/LO already hold the new result
//   md_hi      out 32  HI register
//   md_lo      out 32  LO register
//   md_state   out 2   current FSM state (debug visibility)
//
// Handshake: md_start is taken at a rising edge only while md_busy=0
// (state MD_IDLE); it is otherwise ignored, never queued. md_busy stays high
// for 33 cycles after the accepting edge, then md_done pulses for one cycle
// with md_busy low, so a new md_start may be accepted in the done cycle.
// MTHI/MTLO write only when idle and no start is accepted in that cycle.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 md_start,
  input  t_md_op               md_op,
  input  logic [DATA_32_W-1:0] md_src_a,
  input  logic [DATA_32_W-1:0] md_src_b,
  input  logic                 md_hi_wr,
  input  logic                 md_lo_wr,
  input  logic [DATA_32_W-1:0] md_wr_data,
  output logic                 md_busy,
  output logic                 md_done,
  output logic [DATA_32_W-1:0] md_hi,
  output logic [DATA_32_W-1:0] md_lo,
  output t_md_state            md_state
);

  t_md_state            state, state_nxt;
  logic [4:0]           cnt;
  logic                 is_div_r;
  logic                 res_neg;   // product / quotient sign
  logic                 rem_neg;   // remainder sign = sign of dividend
  logic [DATA_32_W-1:0] a_mag, b_mag;
  logic [63:0]          acc;
  logic [DATA_32_W-1:0] rem;

  logic [63:0]          acc_nxt;
  logic [DATA_32_W-1:0] rem_nxt;
  logic                 in_signed, in_div;
  logic [DATA_32_W-1:0] a_mag_in, b_mag_in;
  logic [63:0]          prod_fix;
  logic [DATA_32_W-1:0] hi_fix, lo_fix;

  assign md_state = state;

  md_step u_md_step (
    .is_div  (is_div_r),
    .acc     (acc),
    .rem     (rem),
    .operand (is_div_r ? b_mag : a_mag),
    .acc_nxt (acc_nxt),
    .rem_nxt (rem_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= MD_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (md_start) state_nxt = MD_RUN;
      MD_RUN:  if (cnt == 5'(MD_ITER - 1)) state_nxt = MD_FIX;
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // Operand decode at start: op[1] selects divide, op[0]=0 selects signed.
  always_comb begin
    in_div    = md_op[1];
    in_signed = ~md_op[0];
    a_mag_in  = md_mag(md_src_a, in_signed);
    b_mag_in  = md_mag(md_src_b, in_signed);
  end

  // Result sign correction and divide-by-zero override.
  always_comb begin
    prod_fix = res_neg ? (~acc + 64'd1) : acc;
    hi_fix   = prod_fix[63:32];
    lo_fix   = prod_fix[31:0];
    if (is_div_r) begin
      if (b_mag == '0) begin
        // Divide by zero: LO all ones, HI the dividend as sampled, which is
        // rebuilt from its magnitude and sign.
        lo_fix = '1;
        hi_fix = rem_neg ? (~a_mag + 1'b1) : a_mag;
      end else begin
        lo_fix = res_neg ? (~acc[31:0] + 1'b1) : acc[31:0];
        hi_fix = rem_neg ? (~rem + 1'b1) : rem;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      is_div_r <= 1'b0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      rem      <= '0;
      md_hi    <= '0;
      md_lo    <= '0;
      md_busy  <= 1'b0;
      md_done  <= 1'b0;
    end else begin
      md_busy <= (state_nxt != MD_IDLE);
      md_done <= (state == MD_FIX);
      case (state)
        MD_IDLE: begin
          if (md_start) begin
            cnt      <= '0;
            is_div_r <= in_div;
            res_neg  <= in_signed & (md_src_a[31] ^ md_src_b[31]);
            rem_neg  <= in_signed & md_src_a[31];
            a_mag    <= a_mag_in;
            b_mag    <= b_mag_in;
            // Multiply shifts the multiplier out of the low half; divide
            // shifts the dividend out of the low half.
            acc      <= {32'd0, in_div ? a_mag_in : b_mag_in};
            rem      <= '0;
          end else begin
            if (md_hi_wr) md_hi <= md_wr_data;
            if (md_lo_wr) md_lo <= md_wr_data;
          end
        end
        MD_RUN: begin
          acc <= acc_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 5'd1;
        end
        MD_FIX: begin
          md_hi <= hi_fix;
          md_lo <= lo_fix;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;
  import mips_pkg::*;

  logic                 clk;
  logic                 rst;
  logic                 md_start;
  t_md_op               md_op;
  logic [DATA_32_W-1:0] md_src_a;
  logic [DATA_32_W-1:0] md_src_b;
  logic                 md_hi_wr;
  logic                 md_lo_wr;
  logic [DATA_32_W-1:0] md_wr_data;
  logic                 md_busy;
  logic                 md_done;
  logic [DATA_32_W-1:0] md_hi;
  logic [DATA_32_W-1:0] md_lo;
  t_md_state            md_state;

  logic [63:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  mult_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .md_start   (md_start),
    .md_op      (md_op),
    .md_src_a   (md_src_a),
    .md_src_b   (md_src_b),
    .md_hi_wr   (md_hi_wr),
    .md_lo_wr   (md_lo_wr),
    .md_wr_data (md_wr_data),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .md_hi      (md_hi),
    .md_lo      (md_lo),
    .md_state   (md_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: {HI, LO} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input t_md_op op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      MD_MULT:  res = 64'(sa * sb);
      MD_MULTU: res = ua * ub;
      MD_DIV: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
    return res;
  endfunction

  // Driver: issue one operation, follow it to md_done, score the result.
  // Called #1 after a rising edge; returns #1 after the edge that raises md_done.
  task automatic run_op(input t_md_op op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb);
    logic [63:0] exp;
    int  edges;
    int  busy_cnt;
    bit  seen;
    exp_q.push_back(model(op, a, b));
    md_start = 1'b1;
    md_op    = op;
    md_src_a = a;
    md_src_b = b;
    @(posedge clk); #1;
    md_start = 1'b0;
    edges    = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (!seen && edges < 40) begin
      if (md_busy) busy_cnt++;
      if (disturb && edges == 4) begin
        md_start   = 1'b1;
        md_op      = MD_MULTU;
        md_src_a   = 32'd3;
        md_src_b   = 32'd3;
        md_lo_wr   = 1'b1;
        md_wr_data = 32'h1;
      end
      @(posedge clk); #1;
      edges++;
      md_start = 1'b0;
      md_lo_wr = 1'b0;
      if (md_done) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    check("latency", 64'(edges), 64'd33);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    check("busy_at_done", 64'(md_busy), 64'd0);
    exp = exp_q.pop_front();
    check("hi", 64'(md_hi), 64'(exp[63:32]));
    check("lo", 64'(md_lo), 64'(exp[31:0]));
  endtask

  initial begin
    rst        = 1'b0;
    md_start   = 1'b0;
    md_op      = MD_MULT;
    md_src_a   = '0;
    md_src_b   = '0;
    md_hi_wr   = 1'b0;
    md_lo_wr   = 1'b0;
    md_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(md_busy), 64'd0);
    check("rst_done", 64'(md_done), 64'd0);
    check("rst_hi", 64'(md_hi), 64'd0);
    check("rst_lo", 64'(md_lo), 64'd0);
    check("rst_state", 64'(md_state), 64'(MD_IDLE));
    rst = 1'b1;
    @(posedge clk); #1;

    // Directed operations, issued back to back (each start lands in the
    // previous done cycle).
    run_op(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
    run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(MD_DIVU,  32'h0000_1234, 32'h0000_0000, 1'b0);
    run_op(MD_DIV,   32'hFFFF_FF00, 32'h0000_0000, 1'b0);
    run_op(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0007, 1'b0);
    run_op(MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 1'b0);

    // MTHI / MTLO while idle
    md_hi_wr   = 1'b1;
    md_wr_data = 32'hA5A5_A5A5;
    @(posedge clk); #1;
    md_hi_wr = 1'b0;
    check("mthi", 64'(md_hi), 64'h0000_0000_A5A5_A5A5);
    md_hi_wr   = 1'b1;
    md_lo_wr   = 1'b1;
    md_wr_data = 32'h1357_9BDF;
    @(posedge clk); #1;
    md_hi_wr = 1'b0;
    md_lo_wr = 1'b0;
    check("mt_both_hi", 64'(md_hi), 64'h0000_0000_1357_9BDF);
    check("mt_both_lo", 64'(md_lo), 64'h0000_0000_1357_9BDF);

    // MTLO and a second start during an operation are ignored
    run_op(MD_MULTU, 32'h0001_0000, 32'h0002_0003, 1'b1);
    run_op(MD_DIV,   32'h7654_3210, 32'hFFFF_FF85, 1'b1);

    // Randomised operations
    for (int i = 0; i < 20; i++) begin
      t_md_op      op;
      logic [31:0] a, b;
      op = t_md_op'($urandom_range(3));
      a  = $urandom;
      b  = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(3) == 0) b = 32'($urandom_range(255));
      run_op(op, a, b, 1'b0);
    end

    // Reset in the middle of an operation
    md_start = 1'b1;
    md_op    = MD_MULTU;
    md_src_a = 32'h1234_5678;
    md_src_b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    md_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_busy", 64'(md_busy), 64'd1);
    rst = 1'b0;
    #1;
    check("midrst_busy", 64'(md_busy), 64'd0);
    check("midrst_done", 64'(md_done), 64'd0);
    check("midrst_hi", 64'(md_hi), 64'd0);
    check("midrst_lo", 64'(md_lo), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    begin
      int done_cnt;
      done_cnt = 0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (md_done) done_cnt++;
      end
      check("post_rst_no_done", 64'(done_cnt), 64'd0);
      check("post_rst_hi", 64'(md_hi), 64'd0);
      check("post_rst_lo", 64'(md_lo), 64'd0);
    end

    // Unit still works after the abort
    run_op(MD_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
